// File: rtl/memory_stage_if.sv
// EX/MEM -> MEM -> MEM/WB bundle for the memory_stage block.
// master: upstream/pipeline side that drives the EX/MEM fields and observes results.
// slave : the memory stage itself.
interface memory_stage_if;
  // EX/MEM pipeline register contents
  logic        XM_MemtoReg;
  logic        XM_RegWrite;
  logic        XM_MemRead;
  logic        XM_MemWrite;
  logic        XM_branch;
  logic [31:0] ALUout;
  logic [31:0] XM_MD;
  logic [4:0]  XM_RD;
  logic [31:0] XM_BT;

  // branch resolution toward IF, and pipeline freeze
  logic        PCSrc;
  logic [31:0] BT;
  logic        stall;

  // MEM/WB pipeline register
  logic        MW_MemtoReg;
  logic        MW_RegWrite;
  logic [31:0] MW_ALUout;
  logic [31:0] MW_MDR;
  logic [4:0]  MW_RD;

  modport master (
    output XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch,
    output ALUout, XM_MD, XM_RD, XM_BT,
    input  PCSrc, BT, stall,
    input  MW_MemtoReg, MW_RegWrite, MW_ALUout, MW_MDR, MW_RD
  );

  modport slave (
    input  XM_MemtoReg, XM_RegWrite, XM_MemRead, XM_MemWrite, XM_branch,
    input  ALUout, XM_MD, XM_RD, XM_BT,
    output PCSrc, BT, stall,
    output MW_MemtoReg, MW_RegWrite, MW_ALUout, MW_MDR, MW_RD
  );
endinterface

// File: rtl/memory_stage.sv
// MEM stage of the 5-stage MIPS pipeline: word loads/stores on a local data
// memory, branch PC-source resolution, and the MEM/WB pipeline register.
// Optional feature macro: MEM_WAIT_EN -- when defined, a wait-state sequencer
// adds WAIT_CYCLES stall cycles to every load/store; when undefined every
// access is single-cycle and stall is tied low.
module memory_stage #(
  parameter int DEPTH       = 256,
  parameter int ADDR_W      = 8,
  parameter int WAIT_CYCLES = 2
) (
  input  logic           clk,
  input  logic           rst,
  memory_stage_if.slave  bus
);

  // data memory (not reset; contents preloaded externally)
  logic [31:0] mem [DEPTH];

  logic [ADDR_W-1:0] addr;
  logic              access;
  logic              stall;

  logic        mw_memtoreg;
  logic        mw_regwrite;
  logic [31:0] mw_aluout;
  logic [31:0] mw_mdr;
  logic [4:0]  mw_rd;

  // byte address to word index; low two bits and upper bits ignored
  assign addr   = bus.ALUout[ADDR_W+1:2];
  assign access = bus.XM_MemRead | bus.XM_MemWrite;

  logic unused_addr_bits;
  assign unused_addr_bits = ^{bus.ALUout[31:ADDR_W+2], bus.ALUout[1:0]};

`ifdef MEM_WAIT_EN
  typedef enum logic {S_IDLE, S_WAIT} state_t;

  localparam logic [3:0] WAIT_LOAD = 4'(WAIT_CYCLES - 1);

  state_t     state, state_next;
  logic [3:0] cnt, cnt_next;
  logic       stall_fsm;

  // wait-state sequencer: state and countdown register
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  // next-state and stall decode; the access completes on the edge where stall is low
  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    stall_fsm  = 1'b0;
    case (state)
      S_IDLE: begin
        if (access && (WAIT_CYCLES != 0)) begin
          stall_fsm  = 1'b1;
          cnt_next   = WAIT_LOAD;
          state_next = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt != 4'd0) begin
          stall_fsm = 1'b1;
          cnt_next  = cnt - 4'd1;
        end else begin
          state_next = S_IDLE;
        end
      end
      default: state_next = S_IDLE;
    endcase
  end

  assign stall = rst & stall_fsm;
`else
  logic unused_cfg;
  assign unused_cfg = ^WAIT_CYCLES;
  assign stall      = 1'b0;
`endif

  // store on the completion edge; a reset edge drops any pending store
  always_ff @(posedge clk) begin
    if (rst && !stall && bus.XM_MemWrite) begin
      mem[addr] <= bus.XM_MD;
    end
  end

  // MEM/WB register: reset, bubble while stalled, or capture on completion
  always_ff @(posedge clk) begin
    if (!rst) begin
      mw_memtoreg <= 1'b0;
      mw_regwrite <= 1'b0;
      mw_aluout   <= '0;
      mw_mdr      <= '0;
      mw_rd       <= '0;
    end else if (stall) begin
      mw_memtoreg <= 1'b0;
      mw_regwrite <= 1'b0;
    end else begin
      mw_memtoreg <= bus.XM_MemtoReg;
      mw_regwrite <= bus.XM_RegWrite;
      mw_aluout   <= bus.ALUout;
      mw_rd       <= bus.XM_RD;
      // MemRead+MemWrite together behaves as a store: MDR holds
      if (bus.XM_MemWrite) begin
        mw_mdr <= mw_mdr;
      end else if (bus.XM_MemRead) begin
        mw_mdr <= mem[addr];
      end else begin
        mw_mdr <= '0;
      end
    end
  end

  assign bus.PCSrc       = rst & bus.XM_branch;
  assign bus.BT          = bus.XM_BT;
  assign bus.stall       = stall;
  assign bus.MW_MemtoReg = mw_memtoreg;
  assign bus.MW_RegWrite = mw_regwrite;
  assign bus.MW_ALUout   = mw_aluout;
  assign bus.MW_MDR      = mw_mdr;
  assign bus.MW_RD       = mw_rd;

endmodule

// File: tb/tb_memory_stage.sv
// Directed bench for memory_stage; expectations follow the build's MEM_WAIT_EN setting.
module tb_memory_stage;

`ifdef MEM_WAIT_EN
  localparam int EXP_WAIT = 2;
`else
  localparam int EXP_WAIT = 0;
`endif

  logic clk;
  logic rst;
  int   passed;
  int   total;
  logic [31:0] last_alu;

  memory_stage_if bus_if ();

  memory_stage #(.DEPTH(256), .ADDR_W(8), .WAIT_CYCLES(2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic mr, input logic mw, input logic regw, input logic mtr,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] md);
    bus_if.XM_MemRead   = mr;
    bus_if.XM_MemWrite  = mw;
    bus_if.XM_RegWrite  = regw;
    bus_if.XM_MemtoReg  = mtr;
    bus_if.XM_RD        = rd;
    bus_if.ALUout       = a;
    bus_if.XM_MD        = md;
    bus_if.XM_branch    = 1'b0;
    bus_if.XM_BT        = '0;
  endtask

  // present one op, ride out its stall cycles, check the MEM/WB result
  task automatic access(input string tag, input logic mr, input logic mw, input logic regw,
                        input logic mtr, input logic [4:0] rd, input logic [31:0] a,
                        input logic [31:0] md, input logic [31:0] exp_mdr);
    int stalls;
    drive(mr, mw, regw, mtr, rd, a, md);
    #1;
    stalls = 0;
    while (bus_if.stall === 1'b1 && stalls < 20) begin
      tick();
      stalls++;
      chk({tag, "_bubble_rw"}, 32'(bus_if.MW_RegWrite), 32'd0);
      chk({tag, "_hold_alu"}, bus_if.MW_ALUout, last_alu);
    end
    chk({tag, "_stall_cycles"}, stalls, EXP_WAIT);
    tick();
    chk({tag, "_mdr"}, bus_if.MW_MDR, exp_mdr);
    chk({tag, "_alu"}, bus_if.MW_ALUout, a);
    chk({tag, "_rd"}, 32'(bus_if.MW_RD), 32'(rd));
    chk({tag, "_rw"}, 32'(bus_if.MW_RegWrite), 32'(regw));
    chk({tag, "_m2r"}, 32'(bus_if.MW_MemtoReg), 32'(mtr));
    last_alu = a;
  endtask

  initial begin
    passed   = 0;
    total    = 0;
    last_alu = '0;

    dut.mem[0]  = 32'h0;
    dut.mem[4]  = 32'h0;
    dut.mem[16] = 32'h0;
    dut.mem[17] = 32'h0;
    dut.mem[32] = 32'h0;

    // reset held two edges with a live R-type op and a branch present
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 1'b0, 5'd5, 32'h1234, 32'h0);
    bus_if.XM_branch = 1'b1;
    tick();
    tick();
    chk("rst_mw_alu", bus_if.MW_ALUout, 32'h0);
    chk("rst_mw_mdr", bus_if.MW_MDR, 32'h0);
    chk("rst_mw_rd", 32'(bus_if.MW_RD), 32'd0);
    chk("rst_mw_rw", 32'(bus_if.MW_RegWrite), 32'd0);
    chk("rst_mw_m2r", 32'(bus_if.MW_MemtoReg), 32'd0);
    chk("rst_stall", 32'(bus_if.stall), 32'd0);
    chk("rst_pcsrc", 32'(bus_if.PCSrc), 32'd0);

    // release: non-memory op completes on the next edge
    rst = 1'b1;
    bus_if.XM_branch = 1'b0;
    #1;
    chk("rel_stall", 32'(bus_if.stall), 32'd0);
    tick();
    chk("rel_alu", bus_if.MW_ALUout, 32'h1234);
    chk("rel_rw", 32'(bus_if.MW_RegWrite), 32'd1);
    chk("rel_rd", 32'(bus_if.MW_RD), 32'd5);
    last_alu = 32'h1234;

    // store then load, same address
    access("sw40", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h40, 32'hDEADBEEF, 32'h0);
    access("lw40", 1'b1, 1'b0, 1'b1, 1'b1, 5'd8, 32'h40, 32'h0, 32'hDEADBEEF);

    // MemRead+MemWrite together: stored, MDR holds previous load data
    access("both44", 1'b1, 1'b1, 1'b0, 1'b0, 5'd0, 32'h44, 32'h12345678, 32'hDEADBEEF);
    access("lw44", 1'b1, 1'b0, 1'b1, 1'b1, 5'd9, 32'h44, 32'h0, 32'h12345678);

    // non-memory op clears MDR
    access("rtype", 1'b0, 1'b0, 1'b1, 1'b0, 5'd3, 32'h77, 32'hFFFFFFFF, 32'h0);

    // address wrap: 0x400 aliases word 0
    access("sw400", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h400, 32'hA5A5A5A5, 32'h0);
    access("lw000", 1'b1, 1'b0, 1'b1, 1'b1, 5'd10, 32'h000, 32'h0, 32'hA5A5A5A5);

    // misaligned low bits ignored
    access("lw403", 1'b1, 1'b0, 1'b1, 1'b1, 5'd11, 32'h403, 32'h0, 32'hA5A5A5A5);

    // branch resolution is combinational
    drive(1'b0, 1'b0, 1'b0, 1'b0, 5'd0, 32'h0, 32'h0);
    bus_if.XM_branch = 1'b1;
    bus_if.XM_BT     = 32'h0000_0100;
    #1;
    chk("br_pcsrc", 32'(bus_if.PCSrc), 32'd1);
    chk("br_bt", bus_if.BT, 32'h100);
    chk("br_stall", 32'(bus_if.stall), 32'd0);
    bus_if.XM_branch = 1'b0;
    #1;
    chk("br_off_pcsrc", 32'(bus_if.PCSrc), 32'd0);
    tick();
    last_alu = 32'h0;

    // reset during a pending store drops it
    drive(1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h80, 32'h11111111);
`ifdef MEM_WAIT_EN
    tick();
`endif
    rst = 1'b0;
    #1;
    chk("rw_stall_in_rst", 32'(bus_if.stall), 32'd0);
    tick();
    chk("rw_mw_alu", bus_if.MW_ALUout, 32'h0);
    rst = 1'b1;
    last_alu = 32'h0;
    access("lw80", 1'b1, 1'b0, 1'b1, 1'b1, 5'd12, 32'h80, 32'h0, 32'h0);

    // back-to-back store/load with no dead cycle
    access("sw10", 1'b0, 1'b1, 1'b0, 1'b0, 5'd0, 32'h10, 32'h5, 32'h0);
    access("lw10", 1'b1, 1'b0, 1'b1, 1'b1, 5'd13, 32'h10, 32'h0, 32'h5);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
